pattern_event_logger: RTL and testbench
=======================================

Name: pattern_event_logger

Overview:
- Sits directly downstream of the even/odd/odd/even number-pattern detector.
- Consumes its sequence_detected level, converts each rising edge into one event, and stamps it with a free-running cycle counter.
- Buffers event timestamps in a small FIFO and drains them to a host over a valid/ready interface.
- Keeps a saturating event count and a sticky overflow flag for status reporting.

Parameters:
- TS_W, 16: timestamp counter width (bits).
- DEPTH, 4: FIFO entries; power of 2, minimum 2.
- CNT_W, 8: width of the event and drop counters (saturating).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- det_in  input  1  sequence_detected from the pattern detector.
- clear  input  1  synchronous clear of the counters and the overflow flag; FIFO contents are kept.
- out_valid  output  1  FIFO not empty; out_ts is valid.
- out_ready  input  1  host accepts the head entry.
- out_ts  output  TS_W  timestamp of the oldest buffered event.
- event_count  output  CNT_W  total events detected, saturating.
- drop_count  output  CNT_W  events lost because the FIFO was full, saturating.
- overflow  output  1  sticky; set on the first drop.

Behaviour:
- Reset state:
  - ts counter = 0, det_q = 0.
  - FIFO empty: out_valid = 0, out_ts = 0.
  - event_count = 0, drop_count = 0, overflow = 0.
- Timestamp:
  - ts increments by 1 every cycle out of reset and wraps modulo 2^TS_W.
  - The clear input does not affect ts.
- Event detection:
  - det_q is det_in registered.
  - event = det_in & ~det_q.
  - A level held high for N cycles counts as one event.
- Push:
  - On the clk edge where event = 1, the current ts value (before its increment) is written.
  - out_valid rises on the following cycle if the FIFO was empty.
  - Event-to-out_valid latency is 1 cycle.
- Pop:
  - A pop occurs when out_valid & out_ready are both high at an edge.
  - The FIFO is first-word-fall-through: out_ts always shows the head entry.
  - out_ts holds its last value when the FIFO is empty.
- Full FIFO:
  - An event arriving with no pop in the same cycle is dropped.
  - On a drop, drop_count increments (saturating) and overflow is set.
  - event_count still increments on a drop.
- Full FIFO with simultaneous push and pop:
  - Both occur and no drop happens.
  - Occupancy stays at DEPTH.
- Empty FIFO with simultaneous push and pop:
  - Impossible, since out_valid = 0.
  - The push proceeds normally.
- Counters:
  - Saturate at 2^CNT_W - 1 and never wrap.
- clear:
  - Zeroes event_count, drop_count and overflow.
  - If an event or drop occurs in the same cycle, clear wins and the counters read 0.
  - The FIFO push still occurs.
- Mid-operation reset:
  - A reset asserted at any cycle empties the FIFO and zeroes everything on the next edge.
  - Pending entries are discarded.
  - An event coinciding with rst is ignored.
- FIFO control:
  - Read and write pointers are log2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.
  - Pointers wrap naturally.
- Control structure:
  - No FSM beyond the pointer logic; all state is in registers.
  - The combinational outputs are out_valid and out_ts, both derived from registers.

Decomposition:
- Shared package pattern_pkg:
  - Default widths: TS_W, CNT_W, DEPTH.
  - The 4-bit number width shared with the detector.
  - A function returning the saturating increment for the counters.
- One sub-module, logger_fifo: a parameterised synchronous FWFT FIFO.
  - Inputs: push, pop, din.
  - Outputs: dout, full, empty.
- The top level contains the edge detect, the ts counter, the drop/count logic and the status flags.

Test Plan:
- Single event, FIFO empty:
  - Stimulus: release reset; det_in pulses high for 1 cycle when ts = 5; out_ready held 1.
  - Required response: out_valid = 1 for exactly 1 cycle with out_ts = 5; event_count = 1.
- Held level:
  - Stimulus: det_in high for 6 cycles starting at ts = 10.
  - Required response: one entry with out_ts = 10; event_count = 1.
- Overflow, DEPTH = 4:
  - Stimulus: out_ready = 0; 6 pulses spaced 2 cycles apart.
  - Required response: FIFO holds the first 4 timestamps in order; drop_count = 2; overflow = 1; event_count = 6.
  - Then raise out_ready: 4 pops in order, and out_valid falls after the 4th.
- Full FIFO with simultaneous push and pop:
  - Stimulus: FIFO full; one cycle with out_ready = 1 and an event.
  - Required response: drop_count unchanged; occupancy stays 4; new ts appears last.
- Saturation and clear:
  - Stimulus: CNT_W = 8; 300 events with out_ready = 1.
  - Required response: event_count stays at 255.
  - Then assert clear in the same cycle as an event: count reads 0, and the FIFO still receives the entry.
- Timestamp wrap and reset:
  - Stimulus: TS_W = 4; event at ts = 15, then another at the next wrap with ts = 1.
  - Required response: out_ts = 15, then out_ts = 1.
  - Then assert rst with 2 entries buffered: out_valid = 0 on the next cycle and all counters = 0.

Source files
------------

// File: rtl/pattern_pkg.sv
// -----------------------------------------------------------------------------
// pattern_pkg
// Shared definitions for the number-pattern detector and its event logger.
//   - Default widths for the event logger (timestamp, counters, FIFO depth).
//   - Number width shared with the upstream even/odd pattern detector.
//   - sat_inc(): saturating increment used by the status counters.
// -----------------------------------------------------------------------------
package pattern_pkg;

    // Number width used by the upstream pattern detector.
    localparam int NUM_W     = 4;

    // Default logger geometry.
    localparam int TS_W_DEF  = 16;
    localparam int CNT_W_DEF = 8;
    localparam int DEPTH_DEF = 4;

    // Returns v + 1, clamped at 2^w - 1. The value is carried in 32 bits
    // so one function serves every counter width up to 32.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (32'd1 << w) - 32'd1;
        if (v >= max_v) begin
            return max_v;
        end
        return v + 32'd1;
    endfunction

endpackage : pattern_pkg

// File: rtl/logger_fifo.sv
// -----------------------------------------------------------------------------
// logger_fifo
// Synchronous first-word-fall-through FIFO holding event timestamps.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (empties the FIFO)
//   push_i   in   write din_i at the tail this cycle
//   pop_i    in   remove the head entry this cycle
//   din_i    in   [W-1:0] data to write
//   dout_o   out  [W-1:0] head entry; holds the last popped value when empty
//   full_o   out  DEPTH entries stored
//   empty_o  out  no entries stored
//
// A push is accepted when the FIFO is not full, or when a pop happens in the
// same cycle (the slot being written is the one being vacated). A pop is
// accepted only when the FIFO is not empty.
// -----------------------------------------------------------------------------
module logger_fifo
    import pattern_pkg::*;
#(
    parameter int W     = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra MSB: equal low bits with differing MSBs
    // means the writer has lapped the reader (full).
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] last_q, last_d;

    logic full;
    logic empty;
    logic pop_ok;
    logic push_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = pop_i && !empty;
    assign push_ok = push_i && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            // Remember what left so dout_o can hold it once empty.
            last_d   = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            last_q   <= last_d;
        end
    end

    // Storage needs no reset: nothing is visible until the pointers move.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

    assign dout_o  = empty ? last_q : mem_q[rd_ptr_q[AW-1:0]];
    assign full_o  = full;
    assign empty_o = empty;

endmodule : logger_fifo

// File: rtl/pattern_event_logger.sv
// -----------------------------------------------------------------------------
// pattern_event_logger
// Turns each rising edge of the pattern detector's sequence_detected level
// into one event, stamps it with a free-running cycle counter, buffers the
// stamps in a FWFT FIFO and drains them to a host. Also keeps saturating
// event/drop counters and a sticky overflow flag.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   det_in       in   sequence_detected level from the pattern detector
//   clear        in   zero event_count, drop_count, overflow (FIFO kept)
//   out_valid    out  FIFO not empty; out_ts is valid
//   out_ready    in   host accepts the head entry
//   out_ts       out  [TS_W-1:0] oldest buffered timestamp
//   event_count  out  [CNT_W-1:0] events detected, saturating
//   drop_count   out  [CNT_W-1:0] events lost to a full FIFO, saturating
//   overflow     out  sticky, set on the first drop
//
// Host handshake: an entry transfers on every clk edge where out_valid and
// out_ready are both high; out_valid never depends on out_ready, and out_ts
// stays stable while out_valid is high and out_ready is low.
// -----------------------------------------------------------------------------
module pattern_event_logger
    import pattern_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             det_in,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TS_W-1:0]  out_ts,
    output logic [CNT_W-1:0] event_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             overflow
);

    localparam logic [TS_W-1:0] TS_ONE = {{(TS_W-1){1'b0}}, 1'b1};

    logic [TS_W-1:0]  ts_q, ts_d;
    logic             det_q;
    logic [CNT_W-1:0] event_cnt_q, event_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             ovf_q, ovf_d;

    logic fifo_full;
    logic fifo_empty;
    logic evt;
    logic pop;
    logic push;
    logic drop;

    // One event per rising edge, however long det_in stays high.
    assign evt  = det_in && !det_q;
    assign pop  = !fifo_empty && out_ready;
    // A full FIFO still accepts the event when the head leaves this cycle.
    assign push = evt && (!fifo_full || pop);
    assign drop = evt && fifo_full && !pop;

    assign ts_d = ts_q + TS_ONE;

    always_comb begin
        event_cnt_d = event_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        ovf_d       = ovf_q;
        if (clear) begin
            // clear wins over a same-cycle event or drop.
            event_cnt_d = '0;
            drop_cnt_d  = '0;
            ovf_d       = 1'b0;
        end else begin
            if (evt) begin
                event_cnt_d = CNT_W'(sat_inc(32'(event_cnt_q), CNT_W));
            end
            if (drop) begin
                drop_cnt_d = CNT_W'(sat_inc(32'(drop_cnt_q), CNT_W));
                ovf_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q        <= '0;
            det_q       <= 1'b0;
            event_cnt_q <= '0;
            drop_cnt_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            ts_q        <= ts_d;
            det_q       <= det_in;
            event_cnt_q <= event_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    logger_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (ts_q),
        .dout_o  (out_ts),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid   = !fifo_empty;
    assign event_count = event_cnt_q;
    assign drop_count  = drop_cnt_q;
    assign overflow    = ovf_q;

endmodule : pattern_event_logger

// File: tb/tb_pattern_event_logger.sv
// -----------------------------------------------------------------------------
// tb_pattern_event_logger
// Directed scenarios followed by random traffic, every cycle compared with a
// queue-based reference model of the logger. TS_W = 4 so timestamp wrap is
// reached quickly.
// -----------------------------------------------------------------------------
module tb_pattern_event_logger;

    localparam int TS_W    = 4;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int TS_MOD  = (1 << TS_W);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst       = 1'b1;
    logic             det_in    = 1'b0;
    logic             clear     = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [TS_W-1:0]  out_ts;
    logic [CNT_W-1:0] event_count;
    logic [CNT_W-1:0] drop_count;
    logic             overflow;

    pattern_event_logger #(
        .TS_W  (TS_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .det_in      (det_in),
        .clear       (clear),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ts      (out_ts),
        .event_count (event_count),
        .drop_count  (drop_count),
        .overflow    (overflow)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_vec = 0;
    int n_err = 0;

    logic [TS_W-1:0] exp_q[$];
    int              m_ts   = 0;
    logic            m_det  = 1'b0;
    int              m_ev   = 0;
    int              m_drop = 0;
    logic            m_ovf  = 1'b0;
    logic [TS_W-1:0] m_last = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge(input logic r, input logic d, input logic rd, input logic c);
        bit ev, pop, drop;
        if (r) begin
            m_ts = 0; m_det = 1'b0; exp_q.delete();
            m_ev = 0; m_drop = 0; m_ovf = 1'b0; m_last = '0;
        end else begin
            ev   = d && !m_det;
            pop  = (exp_q.size() > 0) && rd;
            drop = ev && (exp_q.size() == DEPTH) && !pop;
            if (pop) m_last = exp_q.pop_front();
            if (ev && !drop) exp_q.push_back(TS_W'(m_ts));
            if (c) begin
                m_ev = 0; m_drop = 0; m_ovf = 1'b0;
            end else begin
                if (ev && m_ev < CNT_MAX) m_ev++;
                if (drop) begin
                    if (m_drop < CNT_MAX) m_drop++;
                    m_ovf = 1'b1;
                end
            end
            m_ts  = (m_ts + 1) % TS_MOD;
            m_det = d;
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic d, input logic rd, input logic c);
        logic [TS_W-1:0] exp_ts;
        rst = r; det_in = d; out_ready = rd; clear = c;
        model_edge(r, d, rd, c);
        @(posedge clk);
        #1;
        exp_ts = (exp_q.size() > 0) ? exp_q[0] : m_last;
        chk("out_valid",   32'(out_valid),   32'(exp_q.size() != 0));
        chk("out_ts",      32'(out_ts),      32'(exp_ts));
        chk("event_count", 32'(event_count), 32'(m_ev));
        chk("drop_count",  32'(drop_count),  32'(m_drop));
        chk("overflow",    32'(overflow),    32'(m_ovf));
    endtask

    task automatic pulse(input logic rd);
        step(1'b0, 1'b1, rd, 1'b0);
        step(1'b0, 1'b0, rd, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Single event at ts = 5, host always ready.
        while (m_ts != 5) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("single_ts", 32'(out_ts), 32'd5);
        chk("single_cnt", 32'(event_count), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("single_fall", 32'(out_valid), 32'd0);

        // Level held for 6 cycles from ts = 10 gives one entry.
        while (m_ts != 10) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("held_ts", 32'(out_ts), 32'd10);
        chk("held_cnt", 32'(event_count), 32'd2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("held_one", 32'(out_valid), 32'd0);

        // Overflow: 6 pulses (ts 0,2,..,10) into a stalled FIFO.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6) pulse(1'b0);
        chk("ovf_drop", 32'(drop_count), 32'd2);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_cnt", 32'(event_count), 32'd6);
        chk("ovf_head", 32'(out_ts), 32'd0);
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovf_drained", 32'(out_valid), 32'd0);
        chk("ovf_last", 32'(out_ts), 32'd6);

        // Full FIFO with simultaneous push and pop (event at ts = 8).
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) pulse(1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("fullpp_drop", 32'(drop_count), 32'd0);
        chk("fullpp_head", 32'(out_ts), 32'd2);
        chk("fullpp_depth", 32'(exp_q.size()), 32'd4);
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("fullpp_tail", 32'(out_ts), 32'd8);

        // Saturation, then clear coinciding with an event.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (300) pulse(1'b1);
        chk("sat_cnt", 32'(event_count), 32'd255);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr_cnt", 32'(event_count), 32'd0);
        chk("clr_push", 32'(out_valid), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Timestamp wrap, then reset with entries pending.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        while (m_ts != 15) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("wrap_15", 32'(out_ts), 32'd15);
        while (m_ts != 1) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("wrap_1", 32'(out_ts), 32'd1);
        pulse(1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_cnt", 32'(event_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // Random traffic; host readiness changes character every 200 cycles.
        for (int i = 0; i < 3000; i++) begin
            logic r, d, rd, c;
            int ready_pct;
            ready_pct = ((i / 200) % 3 == 0) ? 10 : (((i / 200) % 3 == 1) ? 50 : 90);
            r  = ($urandom_range(0, 249) == 0);
            d  = ($urandom_range(0, 2) != 0);
            rd = ($urandom_range(0, 99) < ready_pct);
            c  = ($urandom_range(0, 79) == 0);
            step(r, d, rd, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pattern_event_logger
